// File: rtl/controller_fsm_pkg.sv
// Shared types and encodings for the multicycle controller: state enum, opcodes,
// ALU codes, ALUOp and datapath mux selects.
package controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word held in the output register alongside the state.
  typedef struct packed {
    logic [1:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
  } ctl_t;

  function automatic logic op_supported(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  function automatic logic [1:0] imm_sel(logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/controller_fsm_if.sv
// Instruction fields and ALU flag in, datapath control out; master is the controller.
interface controller_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [3:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
    output AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
    input  AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal
  );
endinterface

// File: rtl/controller_fsm_alu_decoder.sv
// Combinational ALUOp/funct decode into the 4-bit ALUControl code.
module alu_decoder
  import controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [3:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only register-register ops carry a subtract; addi ignores bit 30.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: begin
            alucontrol    = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// Multicycle Moore controller: state register, next-state logic, registered
// control word, ALU decoder and immediate select.
module controller_fsm
  import controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  controller_fsm_if.master  bus
);

  state_t state;
  state_t nxt;
  ctl_t   ctl;
  ctl_t   ctl_vis;
  logic [3:0] alucontrol;
  logic       funct_illegal;

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.srca      = SRCA_PC;
        c.srcb      = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALURESULT;
        c.pcupdate  = 1'b1;
      end
      DECODE: begin
        c.srca  = SRCA_OLDPC;
        c.srcb  = SRCB_IMM;
        c.aluop = ALUOP_ADD;
      end
      MEMADR: begin
        c.srca  = SRCA_RS1;
        c.srcb  = SRCB_IMM;
        c.aluop = ALUOP_ADD;
      end
      MEMREAD: begin
        c.resultsrc = RES_ALUOUT;
        c.adrsrc    = 1'b1;
      end
      MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        c.resultsrc = RES_ALUOUT;
        c.adrsrc    = 1'b1;
        c.memwrite  = 1'b1;
      end
      EXECR: begin
        c.srca  = SRCA_RS1;
        c.srcb  = SRCB_RS2;
        c.aluop = ALUOP_FUNCT;
      end
      EXECI: begin
        c.srca  = SRCA_RS1;
        c.srcb  = SRCB_IMM;
        c.aluop = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.regwrite  = 1'b1;
      end
      BEQ: begin
        c.srca      = SRCA_RS1;
        c.srcb      = SRCB_RS2;
        c.aluop     = ALUOP_SUB;
        c.resultsrc = RES_ALUOUT;
        c.branch    = 1'b1;
      end
      JAL: begin
        c.srca      = SRCA_OLDPC;
        c.srcb      = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALUOUT;
        c.pcupdate  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:            nxt = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:           nxt = MEMWB;
      EXECR, EXECI, JAL: nxt = ALUWB;
      default:           nxt = FETCH;
    endcase
  end

  // The control word is registered from the next state so outputs stay Moore
  // and glitch-free; unreachable encodings fall through to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= state_ctl(FETCH);
    end else begin
      state <= nxt;
      ctl   <= state_ctl(nxt);
    end
  end

  // While reset is high the datapath sees the FETCH selects, even before the first edge.
  always_comb begin
    ctl_vis = reset ? state_ctl(FETCH) : ctl;
  end

  alu_decoder u_alu_decoder (
    .aluop         (ctl_vis.aluop),
    .funct3        (bus.funct3),
    .op5           (bus.op[5]),
    .funct7b5      (bus.funct7b5),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  assign bus.ALUControl = alucontrol;
  assign bus.ALUSrcA    = ctl_vis.srca;
  assign bus.ALUSrcB    = ctl_vis.srcb;
  assign bus.ResultSrc  = ctl_vis.resultsrc;
  assign bus.AdrSrc     = ctl_vis.adrsrc;
  assign bus.ImmSrc     = imm_sel(bus.op);

  assign bus.IRWrite  = ctl.irwrite  & ~reset;
  assign bus.RegWrite = ctl.regwrite & ~reset;
  assign bus.MemWrite = ctl.memwrite & ~reset;
  assign bus.PCWrite  = ~reset & (ctl.pcupdate | (ctl.branch & bus.Zero));
  assign bus.Illegal  = ~reset &
                        (((state == DECODE) & ~op_supported(bus.op)) |
                         (((state == EXECR) | (state == EXECI)) & funct_illegal));

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: reset checks, a vector table, corner sequences and
// randomized instructions against a per-instruction phase model.
module tb_controller_fsm;
  import controller_pkg::*;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] imm;
    logic       adr;
    logic       ir;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         cycles;
    int         alu3;
    int         rw;
    int         mw;
    int         pcw;
    int         ill;
  } vec_t;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                 P_XR = 6, P_XI = 7, P_AWB = 8, P_B = 9, P_J = 10;

  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  controller_fsm_if bus ();

  controller_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic outs_t sample();
    outs_t s;
    s.alu = bus.ALUControl; s.sa = bus.ALUSrcA; s.sb = bus.ALUSrcB;
    s.rs  = bus.ResultSrc;  s.imm = bus.ImmSrc; s.adr = bus.AdrSrc;
    s.ir  = bus.IRWrite;    s.pcw = bus.PCWrite; s.rw = bus.RegWrite;
    s.mw  = bus.MemWrite;   s.ill = bus.Illegal;
    return s;
  endfunction

  function automatic logic known_op(logic [6:0] op);
    return op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
           op == 7'h63 || op == 7'h6f;
  endfunction

  function automatic logic [1:0] imm_exp(logic [6:0] op);
    if (op == 7'h23) return 2'd1;
    if (op == 7'h63) return 2'd2;
    if (op == 7'h6f) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [3:0] funct_alu(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'd0:    return (op == 7'h33 && f7) ? 4'd1 : 4'd0;
      3'd2:    return 4'd5;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // Ordered list of phases an instruction class walks through.
  function automatic int nphases(logic [6:0] op);
    case (op)
      7'h03:                return 5;
      7'h23, 7'h33, 7'h13, 7'h6f: return 4;
      7'h63:                return 3;
      default:              return 2;
    endcase
  endfunction

  function automatic int phase_at(logic [6:0] op, int i);
    int s[5];
    s = '{P_F, P_D, P_F, P_F, P_F};
    case (op)
      7'h03: s = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'h23: s = '{P_F, P_D, P_MA, P_MW, P_F};
      7'h33: s = '{P_F, P_D, P_XR, P_AWB, P_F};
      7'h13: s = '{P_F, P_D, P_XI, P_AWB, P_F};
      7'h63: s = '{P_F, P_D, P_B, P_F, P_F};
      7'h6f: s = '{P_F, P_D, P_J, P_AWB, P_F};
      default: ;
    endcase
    return s[i];
  endfunction

  function automatic outs_t model(int ph, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    outs_t o;
    o = '0;
    o.imm = imm_exp(op);
    case (ph)
      P_F:   begin o.sb = 2'd2; o.rs = 2'd2; o.ir = 1'b1; o.pcw = 1'b1; end
      P_D:   begin o.sa = 2'd1; o.sb = 2'd1; o.ill = !known_op(op); end
      P_MA:  begin o.sa = 2'd2; o.sb = 2'd1; end
      P_MR:  o.adr = 1'b1;
      P_MWB: begin o.rs = 2'd1; o.rw = 1'b1; end
      P_MW:  begin o.adr = 1'b1; o.mw = 1'b1; end
      P_XR, P_XI: begin
        o.sa  = 2'd2;
        o.sb  = (ph == P_XR) ? 2'd0 : 2'd1;
        o.alu = funct_alu(op, f3, f7);
        o.ill = !(f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
      end
      P_AWB: o.rw = 1'b1;
      P_B:   begin o.sa = 2'd2; o.alu = 4'd1; o.pcw = z; end
      P_J:   begin o.sa = 2'd1; o.sb = 2'd2; o.pcw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t reset_exp(logic [6:0] op);
    outs_t o;
    o = model(P_F, op, 3'd0, 1'b0, 1'b0);
    o.ir  = 1'b0;
    o.pcw = 1'b0;
    return o;
  endfunction

  task automatic check_outs(input string nm, input outs_t exp);
    outs_t act;
    act = sample();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Entered at #1 after the edge into FETCH; leaves at #1 after the edge into the next FETCH.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7);
    logic z;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int i = 0; i < nphases(op); i++) begin
      z = 1'($urandom_range(0, 1));
      bus.Zero = z;
      @(negedge clk);
      check_outs($sformatf("%s ph%0d", nm, i), model(phase_at(op, i), op, f3, f7, z));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_count(input vec_t v, output int n, output int alu3, output int rw,
                           output int mw, output int pcw, output int ill);
    n = 0; alu3 = 0; rw = 0; mw = 0; pcw = 0; ill = 0;
    bus.op = v.op; bus.funct3 = v.f3; bus.funct7b5 = v.f7; bus.Zero = v.z;
    while (n < 10) begin
      @(negedge clk);
      if (n == 2) alu3 = int'(bus.ALUControl);
      rw  += int'(bus.RegWrite);
      mw  += int'(bus.MemWrite);
      pcw += int'(bus.PCWrite);
      ill += int'(bus.Illegal);
      n++;
      @(posedge clk); #1;
      if (bus.IRWrite) break;
    end
  endtask

  initial begin
    vec_t vt[16];
    int n, alu3, rw, mw, pcw, ill;
    logic [6:0] rop;
    logic [6:0] ops[6];

    vt[0]  = '{7'h33, 3'd0, 1'b1, 1'b1, 4, 1, 1, 0, 1, 0};
    vt[1]  = '{7'h33, 3'd0, 1'b0, 1'b0, 4, 0, 1, 0, 1, 0};
    vt[2]  = '{7'h33, 3'd2, 1'b0, 1'b1, 4, 5, 1, 0, 1, 0};
    vt[3]  = '{7'h33, 3'd6, 1'b0, 1'b0, 4, 3, 1, 0, 1, 0};
    vt[4]  = '{7'h33, 3'd7, 1'b0, 1'b0, 4, 2, 1, 0, 1, 0};
    vt[5]  = '{7'h33, 3'd1, 1'b0, 1'b0, 4, 0, 1, 0, 1, 1};
    vt[6]  = '{7'h13, 3'd0, 1'b1, 1'b0, 4, 0, 1, 0, 1, 0};
    vt[7]  = '{7'h13, 3'd2, 1'b0, 1'b0, 4, 5, 1, 0, 1, 0};
    vt[8]  = '{7'h13, 3'd6, 1'b0, 1'b0, 4, 3, 1, 0, 1, 0};
    vt[9]  = '{7'h13, 3'd7, 1'b0, 1'b1, 4, 2, 1, 0, 1, 0};
    vt[10] = '{7'h03, 3'd2, 1'b0, 1'b0, 5, 0, 1, 0, 1, 0};
    vt[11] = '{7'h23, 3'd2, 1'b0, 1'b1, 4, 0, 0, 1, 1, 0};
    vt[12] = '{7'h63, 3'd0, 1'b0, 1'b1, 3, 1, 0, 0, 2, 0};
    vt[13] = '{7'h63, 3'd0, 1'b0, 1'b0, 3, 1, 0, 0, 1, 0};
    vt[14] = '{7'h6f, 3'd0, 1'b0, 1'b0, 4, 0, 1, 0, 2, 0};
    vt[15] = '{7'h7f, 3'd0, 1'b0, 1'b0, 2, 0, 0, 0, 1, 1};
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};

    // Reset held three cycles, then released straight into an R-type sub.
    reset = 1'b1;
    bus.op = 7'h33; bus.funct3 = 3'd0; bus.funct7b5 = 1'b1; bus.Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("reset cyc%0d", i), reset_exp(7'h33));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    run_instr("r_sub", 7'h33, 3'd0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      run_count(vt[k], n, alu3, rw, mw, pcw, ill);
      check_int($sformatf("vec%0d cycles", k), n, vt[k].cycles);
      check_int($sformatf("vec%0d alu3", k), alu3, vt[k].alu3);
      check_int($sformatf("vec%0d regwrite", k), rw, vt[k].rw);
      check_int($sformatf("vec%0d memwrite", k), mw, vt[k].mw);
      check_int($sformatf("vec%0d pcwrite", k), pcw, vt[k].pcw);
      check_int($sformatf("vec%0d illegal", k), ill, vt[k].ill);
    end

    // Resynchronise with a reset pulse, then abort a lw in MEMREAD.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.op = 7'h03; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_outs("lw memread", model(P_MR, 7'h03, 3'd2, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    check_outs("reset in memread", reset_exp(7'h03));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("lw after abort", 7'h03, 3'd2, 1'b0);
    run_instr("sw", 7'h23, 3'd2, 1'b0);
    run_instr("illegal op", 7'h7f, 3'd0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 6) == 0) rop = 7'($urandom);
      else rop = ops[$urandom_range(0, 5)];
      run_instr($sformatf("rand%0d op%h", k, rop), rop, 3'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controller_fsm.md
# controller_fsm

Multicycle control unit that drives the datapath around the 32-bit ALU. A Moore state machine sequences fetch, decode, execute, memory and writeback. A combinational ALU decoder produces the 4-bit `ALUControl` code that the ALU consumes, and `Zero` from the ALU comes back here for branch resolution. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

## Interface
- No parameters. Widths are fixed by the ISA.
- `clk` input 1: single clock. Everything updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 7: instruction[6:0], taken from the instruction register.
- `funct3` input 3: instruction[14:12].
- `funct7b5` input 1: instruction[30].
- `Zero` input 1: ALU zero flag. Only meaningful for a subtraction.
- `ALUControl` output 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt.
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 rs1 register.
- `ALUSrcB` output 2: 00 rs2 register, 01 ImmExt, 10 constant 4.
- `ResultSrc` output 2: 00 ALUOut, 01 memory Data, 10 ALUResult.
- `ImmSrc` output 2: 00 I-type, 01 S-type, 10 B-type, 11 J-type. Combinational from `op`; unknown `op` gives 00.
- `AdrSrc` output 1: memory address select, 0 PC, 1 ResultSrc path.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` output 1 each: datapath write enables.
- `Illegal` output 1: one-cycle pulse when the opcode or funct3 is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH→DECODE.
  - DECODE goes by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; anything else → FETCH with `Illegal`=1.
  - MEMADR → MEMREAD for lw, → MEMWRITE for sw.
  - MEMREAD→MEMWB.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Outputs per state. Unlisted signals are 0. ALUOp is internal.
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: SrcA=01, SrcB=01, ALUOp=00 (computes the branch target).
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: SrcA=10, SrcB=00, ALUOp=10.
  - EXECI: SrcA=10, SrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & `Zero`).
- ALU decoder:
  - ALUOp 00 → 0000 (add).
  - ALUOp 01 → 0001 (sub).
  - ALUOp 10 decodes `funct3`:
    - 000 → 0001 if `op`[5] & `funct7b5`, else 0000.
    - 010 → 0101.
    - 110 → 0011.
    - 111 → 0010.
    - Any other value → 0000 with `Illegal`=1, only in EXECR/EXECI.
- Outputs are never X. Any unreachable state encoding recovers to FETCH on the next edge.

## Timing
- Reset:
  - `reset` high at an edge puts the state in FETCH.
  - While `reset` is high, `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` and `Illegal` are forced to 0.
  - All other outputs show the FETCH values: ALUControl=0000, SrcA=00, SrcB=10, ResultSrc=10, AdrSrc=0.
  - A reset mid-instruction aborts it. No partial write happens in the reset cycle.
- Latency in cycles, counted from FETCH: lw 5; sw, R, I and jal 4; beq 3; illegal opcode 2.
- State outputs are Moore. `PCWrite` and `Illegal` also depend on inputs in the current cycle. `Zero` is sampled combinationally in BEQ only.
- `op` and `funct*` must be stable from DECODE through the end of the instruction, which the IR guarantees because `IRWrite` is 0.

## Structure
- Package `controller_pkg` holds:
  - the state enum;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - the ALUControl codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - the ALUOp and mux-select encodings.
- Sub-module `alu_decoder` (combinational): inputs ALUOp, funct3, op[5], funct7b5; outputs ALUControl and a funct-illegal flag.
- The top level holds the state register, next-state logic, the output decode and `ImmSrc`.

## Test plan
- Reset held 3 cycles, then released with op=0110011: `IRWrite`=0 during reset; cycle 1 after release is FETCH with `IRWrite`=1, `PCWrite`=1, ALUControl=0000.
- R-type sub, funct3=000, funct7b5=1: states FETCH, DECODE, EXECR, ALUWB; ALUControl=0001 in EXECR; `RegWrite`=1 only in ALUWB.
- addi with funct7b5=1 (op[5]=0): EXECI gives ALUControl=0000, not sub. slti gives 0101; ori gives 0011; andi gives 0010.
- lw then sw:
  - lw visits 5 states with `AdrSrc`=1 in MEMREAD and ResultSrc=01 plus `RegWrite` in MEMWB.
  - sw has `MemWrite`=1 only in MEMWRITE, with ImmSrc=01.
- beq: with Zero=1 in the BEQ state, `PCWrite`=1 and ALUControl=0001; with Zero=0, `PCWrite`=0; both return to FETCH.
- op=1111111: `Illegal`=1 in DECODE, next state FETCH, no write enables asserted. A reset asserted in MEMREAD forces FETCH with `RegWrite` never pulsing.
